// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants for the hazard detection slice.
// Holds the mult/div occupancy state enum and register-index helpers.
package mips_pipe_pkg;

    localparam int REG_W    = 5;
    localparam int MD_CNT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_reg_match.sv
// Producer-vs-consumer register comparator.
// Ports: src_reg (producer index), rs/rt/uses_rt (consumer), match.
// match = src_reg nonzero and equal to rs, or to rt when uses_rt.
module hazard_reg_match
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0] src_reg,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             match
);

    always_comb begin
        match = 1'b0;
        if (src_reg != REG_ZERO) begin
            match = (src_reg == rs) || (uses_rt && (src_reg == rt));
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush control for hazards that bypassing cannot resolve:
// load-use, ID-stage branch operands, and HI/LO reads while mult/div busy.
// Inputs: IF/ID, ID/EX, EX/MEM fields plus branchTaken.
// Outputs: pcWrite, ifidWrite, idexBubble, ifidFlush, mdBusy, stallCycles.
module hazard_detection_unit
    import mips_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IFID_rs,
    input  logic [4:0]           IFID_rt,
    input  logic                 IFID_usesRt,
    input  logic                 IFID_branch,
    input  logic                 IFID_readsHiLo,
    input  logic                 IFID_mulDiv,
    input  logic [4:0]           IDEX_rt,
    input  logic [4:0]           IDEX_rd,
    input  logic                 IDEX_memRead,
    input  logic                 IDEX_regWrite,
    input  logic                 IDEX_mulDiv,
    input  logic [4:0]           EXMEM_rd,
    input  logic                 EXMEM_memRead,
    input  logic                 branchTaken,
    output logic                 pcWrite,
    output logic                 ifidWrite,
    output logic                 idexBubble,
    output logic                 ifidFlush,
    output logic                 mdBusy,
    output logic [CNT_WIDTH-1:0] stallCycles
);

    localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   md_count_q, md_count_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    logic ld_match, ex_match, mem_match;
    logic load_use, br_haz, md_haz, stall;

    hazard_reg_match u_match_ld (
        .src_reg (IDEX_rt),
        .rs      (IFID_rs),
        .rt      (IFID_rt),
        .uses_rt (IFID_usesRt),
        .match   (ld_match)
    );

    hazard_reg_match u_match_ex (
        .src_reg (IDEX_rd),
        .rs      (IFID_rs),
        .rt      (IFID_rt),
        .uses_rt (IFID_usesRt),
        .match   (ex_match)
    );

    hazard_reg_match u_match_mem (
        .src_reg (EXMEM_rd),
        .rs      (IFID_rs),
        .rt      (IFID_rt),
        .uses_rt (IFID_usesRt),
        .match   (mem_match)
    );

    always_comb begin
        load_use = IDEX_memRead && ld_match;
        // ALU results are forwarded into ID only from MEM, so an EX
        // producer stalls once; a load in MEM must wait for WB.
        br_haz   = IFID_branch &&
                   ((IDEX_regWrite && ex_match) ||
                    (EXMEM_memRead && mem_match));
        // The final busy cycle (count==0) lets HI/LO readers through.
        md_haz   = (state_q == MD_BUSY) && (md_count_q != '0) &&
                   (IFID_readsHiLo || IFID_mulDiv);
        // Reset suppresses stalls so the pipe restarts cleanly.
        stall    = !reset && (load_use || br_haz || md_haz);
    end

    always_comb begin
        pcWrite    = !stall;
        ifidWrite  = !stall;
        idexBubble = stall;
        // A stalled branch re-resolves next cycle, so hold off the flush.
        ifidFlush  = branchTaken && !stall;
        mdBusy     = (state_q == MD_BUSY);
    end

    always_comb begin
        state_d    = state_q;
        md_count_d = md_count_q;
        unique case (state_q)
            RUN: begin
                if (IDEX_mulDiv) begin
                    state_d    = MD_BUSY;
                    md_count_d = MD_RELOAD;
                end
            end
            MD_BUSY: begin
                if (md_count_q != '0) begin
                    // A new mult/div here is impossible (held in ID).
                    md_count_d = md_count_q - 1'b1;
                end else if (IDEX_mulDiv) begin
                    md_count_d = MD_RELOAD;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                md_count_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            md_count_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_count_q  <= md_count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios
// followed by random traffic, compared against a behavioural model.
module tb_hazard_detection_unit;

    localparam int LAT = 4;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    IFID_rs, IFID_rt, IDEX_rt, IDEX_rd, EXMEM_rd;
    logic          IFID_usesRt, IFID_branch, IFID_readsHiLo, IFID_mulDiv;
    logic          IDEX_memRead, IDEX_regWrite, IDEX_mulDiv;
    logic          EXMEM_memRead, branchTaken;
    logic          pcWrite, ifidWrite, idexBubble, ifidFlush, mdBusy;
    logic [CW-1:0] stallCycles;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Model: md_left = busy cycles still to be shown (0 = idle).
    int            md_left;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    hazard_detection_unit #(
        .MD_LATENCY (LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_usesRt    (IFID_usesRt),
        .IFID_branch    (IFID_branch),
        .IFID_readsHiLo (IFID_readsHiLo),
        .IFID_mulDiv    (IFID_mulDiv),
        .IDEX_rt        (IDEX_rt),
        .IDEX_rd        (IDEX_rd),
        .IDEX_memRead   (IDEX_memRead),
        .IDEX_regWrite  (IDEX_regWrite),
        .IDEX_mulDiv    (IDEX_mulDiv),
        .EXMEM_rd       (EXMEM_rd),
        .EXMEM_memRead  (EXMEM_memRead),
        .branchTaken    (branchTaken),
        .pcWrite        (pcWrite),
        .ifidWrite      (ifidWrite),
        .idexBubble     (idexBubble),
        .ifidFlush      (ifidFlush),
        .mdBusy         (mdBusy),
        .stallCycles    (stallCycles)
    );

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) &&
               ((r == IFID_rs) || (IFID_usesRt && r == IFID_rt));
    endfunction

    function automatic bit m_stall();
        bit lu, bh, mh;
        if (reset) return 1'b0;
        lu = IDEX_memRead && reads(IDEX_rt);
        bh = IFID_branch &&
             ((IDEX_regWrite && reads(IDEX_rd)) ||
              (EXMEM_memRead && reads(EXMEM_rd)));
        mh = (md_left > 1) && (IFID_readsHiLo || IFID_mulDiv);
        return lu || bh || mh;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs,
                       input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        IFID_rs = 0; IFID_rt = 0; IFID_usesRt = 0; IFID_branch = 0;
        IFID_readsHiLo = 0; IFID_mulDiv = 0;
        IDEX_rt = 0; IDEX_rd = 0; IDEX_memRead = 0;
        IDEX_regWrite = 0; IDEX_mulDiv = 0;
        EXMEM_rd = 0; EXMEM_memRead = 0; branchTaken = 0;
    endtask

    task automatic step(input string tag);
        bit s;
        @(negedge clk);
        s = m_stall();
        n_checks++;
        assert (!(IDEX_mulDiv && md_left > 1 && !reset)) else begin
            n_fail++;
            $error("FAIL %s_mdproto: mult/div entered EX while busy", tag);
        end
        chk({tag, "_pcWrite"},    CW'(pcWrite),    CW'(!s));
        chk({tag, "_ifidWrite"},  CW'(ifidWrite),  CW'(!s));
        chk({tag, "_idexBubble"}, CW'(idexBubble), CW'(s));
        chk({tag, "_ifidFlush"},  CW'(ifidFlush),  CW'(branchTaken && !s));
        chk({tag, "_mdBusy"},     CW'(mdBusy),     CW'(md_left > 0));
        chk({tag, "_stallCyc"},   stallCycles,     m_cnt);
        @(posedge clk);
        if (reset) begin
            md_left = 0;
            m_cnt   = 0;
        end else begin
            if (s && m_cnt != '1) m_cnt = m_cnt + 1;
            if (md_left > 1)      md_left = md_left - 1;
            else if (IDEX_mulDiv) md_left = LAT;
            else                  md_left = 0;
        end
        #1;
    endtask

    initial begin
        md_left = 0;
        m_cnt   = 0;
        idle();
        reset = 1'b1;
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("idle");

        // Load-use
        IDEX_memRead = 1; IDEX_rt = 8; IFID_rs = 8;
        step("lu_hit");
        idle();
        step("lu_after");
        chk("lu_count", stallCycles, 32'd1);
        IDEX_memRead = 1; IDEX_rt = 0; IFID_rs = 0;
        step("lu_r0");

        // Branch on a load result: two stall cycles
        idle();
        IFID_branch = 1; IFID_rs = 9;
        IDEX_memRead = 1; IDEX_regWrite = 1; IDEX_rd = 9; IDEX_rt = 9;
        step("br_ex");
        IDEX_memRead = 0; IDEX_regWrite = 0; IDEX_rd = 0; IDEX_rt = 0;
        EXMEM_memRead = 1; EXMEM_rd = 9;
        step("br_mem");
        EXMEM_memRead = 0; EXMEM_rd = 0;
        step("br_go");
        chk("br_count", stallCycles, 32'd3);

        // Flush priority
        idle();
        branchTaken = 1; IDEX_memRead = 1; IDEX_rt = 4; IFID_rs = 4;
        step("fl_stall");
        IDEX_memRead = 0; IDEX_rt = 0;
        step("fl_flush");
        chk("fl_out", CW'(ifidFlush), CW'(1));

        // Mult/div busy then mfhi
        idle();
        IDEX_mulDiv = 1;
        step("md_start");
        IDEX_mulDiv = 0; IFID_readsHiLo = 1;
        for (int i = 0; i < LAT; i++) step("md_mfhi");
        IFID_readsHiLo = 0;
        step("md_idle");

        // Back-to-back mult/div with reload, then reset mid-busy
        IDEX_mulDiv = 1;
        step("bb_first");
        IDEX_mulDiv = 0; IFID_mulDiv = 1;
        for (int i = 0; i < LAT - 1; i++) step("bb_hold");
        IFID_mulDiv = 0; IDEX_mulDiv = 1;
        step("bb_reload");
        IDEX_mulDiv = 0; IFID_readsHiLo = 1;
        step("bb_cnt2");
        reset = 1'b1;
        step("rst_mid");
        reset = 1'b0;
        step("rst_after");
        chk("rst_busy", CW'(mdBusy), CW'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            IFID_rs        = 5'($urandom_range(0, 3));
            IFID_rt        = 5'($urandom_range(0, 3));
            IFID_usesRt    = 1'($urandom);
            IFID_branch    = 1'($urandom);
            IFID_readsHiLo = ($urandom_range(0, 3) == 0);
            IFID_mulDiv    = ($urandom_range(0, 5) == 0);
            IDEX_rt        = 5'($urandom_range(0, 3));
            IDEX_rd        = 5'($urandom_range(0, 3));
            IDEX_memRead   = 1'($urandom);
            IDEX_regWrite  = 1'($urandom);
            IDEX_mulDiv    = (md_left <= 1) && ($urandom_range(0, 4) == 0);
            EXMEM_rd       = 5'($urandom_range(0, 3));
            EXMEM_memRead  = 1'($urandom);
            branchTaken    = 1'($urandom);
            reset          = ($urandom_range(0, 60) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
